// File: rtl/mod_exp_if.sv
// Start/result bundle of the modular exponentiator.
interface mod_exp_if #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned EXP_WIDTH = 16
);
  logic                 ready_in;
  logic [WIDTH-1:0]     base_in;
  logic [EXP_WIDTH-1:0] exponent_in;
  logic [WIDTH-1:0]     modulus_in;
  logic [WIDTH-1:0]     result_out;
  logic                 busy_out;
  logic                 valid_out;
  logic                 error_out;

  modport master (
    output ready_in, base_in, exponent_in, modulus_in,
    input  result_out, busy_out, valid_out, error_out
  );

  modport slave (
    input  ready_in, base_in, exponent_in, modulus_in,
    output result_out, busy_out, valid_out, error_out
  );
endinterface

// File: rtl/mod_exp.sv
// Modular exponentiator (right-to-left square-and-multiply) with its
// serial reduction and squaring sub-blocks.

// Serial restoring reduction: result = value_in mod modulus_in, one bit per cycle.
module modulus #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               ready_in,
  input  logic [2*WIDTH-1:0] value_in,
  input  logic [WIDTH-1:0]   modulus_in,
  output logic               busy_out,
  output logic               valid_out,
  output logic [WIDTH-1:0]   result_out
);
  localparam int unsigned VW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(VW + 1);

  logic [VW-1:0]    val_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] res_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             valid_q;
  logic [WIDTH:0]   trial_c;
  logic [WIDTH-1:0] rem_c;

  // Shift in the next dividend bit and subtract the modulus when it fits.
  always_comb begin
    trial_c = {rem_q, val_q[VW-1]};
    rem_c   = WIDTH'(trial_c);
    if (trial_c >= {1'b0, modulus_in}) begin
      rem_c = WIDTH'(trial_c - {1'b0, modulus_in});
    end
  end

  // Accept a request when idle, then iterate over all dividend bits.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      val_q   <= '0;
      rem_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (busy_q) begin
        rem_q <= rem_c;
        val_q <= val_q << 1;
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          busy_q  <= 1'b0;
          valid_q <= 1'b1;
          res_q   <= rem_c;
        end
      end else if (ready_in) begin
        busy_q <= 1'b1;
        val_q  <= value_in;
        rem_q  <= '0;
        cnt_q  <= CW'(VW);
      end
    end
  end

  assign busy_out   = busy_q;
  assign valid_out  = valid_q;
  assign result_out = res_q;
endmodule

// Modular squaring: square_out = value_in^2 mod modulus_in.
module square #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             ready_in,
  input  logic [WIDTH-1:0] value_in,
  input  logic [WIDTH-1:0] modulus_in,
  output logic             busy_out,
  output logic             valid_out,
  output logic [WIDTH-1:0] square_out
);
  localparam int unsigned PW = 2 * WIDTH;

  // value_in is held stable by the requester, so the full product can feed the reducer directly.
  modulus #(.WIDTH(WIDTH)) u_red (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .ready_in   (ready_in),
    .value_in   (PW'(value_in) * PW'(value_in)),
    .modulus_in (modulus_in),
    .busy_out   (busy_out),
    .valid_out  (valid_out),
    .result_out (square_out)
  );
endmodule

module mod_exp #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned EXP_WIDTH = 16
) (
  input  logic     clk_in,
  input  logic     rst_in,
  mod_exp_if.slave bus
);
  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [2:0] {IDLE, REDUCE, CHECK, MULT, SHIFT, SQUARE, DONE} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     b_q, b_d, acc_q, acc_d, m_q, m_d;
  logic [EXP_WIDTH-1:0] e_q, e_d;
  logic [PW-1:0]        prod_q, prod_d;
  logic                 err_q, err_d, issued_q, issued_d;
  logic                 mod_rdy_q, mod_rdy_d, sq_rdy_q, sq_rdy_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 busy_q, busy_d, valid_q, valid_d, error_q, error_d;
  logic                 mod_busy, mod_valid, sq_busy, sq_valid;
  logic [WIDTH-1:0]     mod_res, sq_res;

  // prod_q doubles as the held operand for both the initial reduction and the multiply reduction.
  modulus #(.WIDTH(WIDTH)) u_mod (
    .clk_in (clk_in), .rst_in (rst_in), .ready_in (mod_rdy_q),
    .value_in (prod_q), .modulus_in (m_q),
    .busy_out (mod_busy), .valid_out (mod_valid), .result_out (mod_res)
  );

  square #(.WIDTH(WIDTH)) u_sq (
    .clk_in (clk_in), .rst_in (rst_in), .ready_in (sq_rdy_q),
    .value_in (b_q), .modulus_in (m_q),
    .busy_out (sq_busy), .valid_out (sq_valid), .square_out (sq_res)
  );

  // State and datapath registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      b_q       <= '0;
      acc_q     <= '0;
      m_q       <= '0;
      e_q       <= '0;
      prod_q    <= '0;
      err_q     <= 1'b0;
      issued_q  <= 1'b0;
      mod_rdy_q <= 1'b0;
      sq_rdy_q  <= 1'b0;
      result_q  <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      m_q       <= m_d;
      e_q       <= e_d;
      prod_q    <= prod_d;
      err_q     <= err_d;
      issued_q  <= issued_d;
      mod_rdy_q <= mod_rdy_d;
      sq_rdy_q  <= sq_rdy_d;
      result_q  <= result_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      error_q   <= error_d;
    end
  end

  // Next-state, sub-block request pulses and output updates.
  always_comb begin
    state_d   = state_q;
    b_d       = b_q;
    acc_d     = acc_q;
    m_d       = m_q;
    e_d       = e_q;
    prod_d    = prod_q;
    err_d     = err_q;
    issued_d  = issued_q;
    mod_rdy_d = 1'b0;
    sq_rdy_d  = 1'b0;
    result_d  = result_q;
    busy_d    = busy_q;
    valid_d   = 1'b0;
    error_d   = error_q;
    case (state_q)
      IDLE: begin
        if (bus.ready_in) begin
          b_d      = bus.base_in;
          e_d      = bus.exponent_in;
          m_d      = bus.modulus_in;
          acc_d    = WIDTH'(1);
          busy_d   = 1'b1;
          error_d  = 1'b0;
          err_d    = 1'b0;
          issued_d = 1'b0;
          if (bus.modulus_in == '0) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else if (bus.modulus_in == WIDTH'(1)) begin
            acc_d   = '0;
            state_d = DONE;
          end else begin
            state_d = REDUCE;
          end
        end
      end
      REDUCE: begin
        if (!issued_q) begin
          if (!mod_busy) begin
            prod_d    = PW'(b_q);
            mod_rdy_d = 1'b1;
            issued_d  = 1'b1;
          end
        end else if (mod_valid) begin
          b_d      = mod_res;
          issued_d = 1'b0;
          state_d  = CHECK;
        end
      end
      CHECK: begin
        if (e_q == '0)     state_d = DONE;
        else if (e_q[0])   state_d = MULT;
        else               state_d = SHIFT;
      end
      MULT: begin
        if (!issued_q) begin
          if (!mod_busy) begin
            prod_d    = PW'(acc_q) * PW'(b_q);
            mod_rdy_d = 1'b1;
            issued_d  = 1'b1;
          end
        end else if (mod_valid) begin
          acc_d    = mod_res;
          issued_d = 1'b0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        e_d = e_q >> 1;
        // The square after the last exponent bit would be wasted work.
        state_d = ((e_q >> 1) == '0) ? DONE : SQUARE;
      end
      SQUARE: begin
        if (!issued_q) begin
          if (!sq_busy) begin
            sq_rdy_d = 1'b1;
            issued_d = 1'b1;
          end
        end else if (sq_valid) begin
          b_d      = sq_res;
          issued_d = 1'b0;
          state_d  = CHECK;
        end
      end
      DONE: begin
        result_d = err_q ? '0 : acc_q;
        valid_d  = 1'b1;
        busy_d   = 1'b0;
        error_d  = err_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.result_out = result_q;
  assign bus.busy_out   = busy_q;
  assign bus.valid_out  = valid_q;
  assign bus.error_out  = error_q;
endmodule

// File: tb/tb_mod_exp.sv
// Directed bench for mod_exp: hand-computed vectors plus a few model-checked random ones.
module tb_mod_exp;
  localparam int unsigned LIMIT = 4000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  mod_exp_if #(.WIDTH(16), .EXP_WIDTH(16)) bus ();

  mod_exp #(.WIDTH(16), .EXP_WIDTH(16)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_exp(input logic [15:0] b, input logic [15:0] e,
                                          input logic [15:0] m);
    longint unsigned r, x, ee;
    if (m == 16'd0) return 16'd0;
    x  = longint'(b) % longint'(m);
    r  = 1 % longint'(m);
    ee = longint'(e);
    while (ee != 0) begin
      if ((ee & 1) != 0) r = (r * x) % longint'(m);
      x  = (x * x) % longint'(m);
      ee = ee >> 1;
    end
    return 16'(r);
  endfunction

  // One-cycle start pulse; returns on the negedge after the accepting edge.
  task automatic start(input logic [15:0] b, input logic [15:0] e, input logic [15:0] m);
    @(negedge clk);
    bus.base_in     = b;
    bus.exponent_in = e;
    bus.modulus_in  = m;
    bus.ready_in    = 1'b1;
    @(negedge clk);
    bus.ready_in    = 1'b0;
  endtask

  // Waits (bounded) for valid_out, tracking whether busy_out stayed high meanwhile.
  task automatic wait_done(output int cyc, output bit busy_all);
    cyc = 0;
    busy_all = 1'b1;
    while (!bus.valid_out && cyc < LIMIT) begin
      if (!bus.busy_out) busy_all = 1'b0;
      @(negedge clk);
      cyc++;
    end
    check("timeout", 32'(cyc < LIMIT), 32'd1);
  endtask

  task automatic run(input string tag, input logic [15:0] b, input logic [15:0] e,
                     input logic [15:0] m, input logic [15:0] exp_res, input logic exp_err);
    int cyc;
    bit busy_all;
    start(b, e, m);
    check({tag, "_busy_start"}, 32'(bus.busy_out), 32'd1);
    wait_done(cyc, busy_all);
    check({tag, "_busy_whole_run"}, 32'(busy_all), 32'd1);
    check({tag, "_result"}, 32'(bus.result_out), 32'(exp_res));
    check({tag, "_error"}, 32'(bus.error_out), 32'(exp_err));
    check({tag, "_busy_fall"}, 32'(bus.busy_out), 32'd0);
    @(negedge clk);
    check({tag, "_valid_one_cycle"}, 32'(bus.valid_out), 32'd0);
    check({tag, "_result_held"}, 32'(bus.result_out), 32'(exp_res));
  endtask

  initial begin
    int cyc;
    bit busy_all;
    bit saw;
    logic [15:0] rb, re, rm;

    bus.ready_in = 1'b0;
    bus.base_in = '0;
    bus.exponent_in = '0;
    bus.modulus_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_result", 32'(bus.result_out), 32'd0);
    check("rst_busy", 32'(bus.busy_out), 32'd0);
    check("rst_valid", 32'(bus.valid_out), 32'd0);
    check("rst_error", 32'(bus.error_out), 32'd0);

    run("3^5m7", 16'd3, 16'd5, 16'd7, 16'd5, 1'b0);
    run("2^10m1000", 16'd2, 16'd10, 16'd1000, 16'd24, 1'b0);
    run("20^3m7", 16'd20, 16'd3, 16'd7, 16'd6, 1'b0);
    run("5^0m13", 16'd5, 16'd0, 16'd13, 16'd1, 1'b0);
    run("9^4m1", 16'd9, 16'd4, 16'd1, 16'd0, 1'b0);
    run("0^7m11", 16'd0, 16'd7, 16'd11, 16'd0, 1'b0);

    // Modulus zero: flagged error, no sub-block work so completion is immediate.
    start(16'd4, 16'd3, 16'd0);
    wait_done(cyc, busy_all);
    check("m0_fast", 32'(cyc <= 2), 32'd1);
    check("m0_error", 32'(bus.error_out), 32'd1);
    check("m0_result", 32'(bus.result_out), 32'd0);
    @(negedge clk);
    check("m0_error_held", 32'(bus.error_out), 32'd1);
    start(16'd3, 16'd5, 16'd7);
    check("err_clear_on_start", 32'(bus.error_out), 32'd0);
    wait_done(cyc, busy_all);
    check("after_err_result", 32'(bus.result_out), 32'd5);

    // Start request while busy must be ignored.
    start(16'd3, 16'd5, 16'd7);
    repeat (10) @(negedge clk);
    bus.base_in = 16'd2; bus.exponent_in = 16'd10; bus.modulus_in = 16'd1000;
    bus.ready_in = 1'b1;
    @(negedge clk);
    bus.ready_in = 1'b0;
    bus.base_in = 16'd99; bus.exponent_in = 16'd99; bus.modulus_in = 16'd99;
    wait_done(cyc, busy_all);
    check("ignore_result", 32'(bus.result_out), 32'd5);
    check("ignore_busy_all", 32'(busy_all), 32'd1);
    run("next_after_valid", 16'd2, 16'd10, 16'd1000, 16'd24, 1'b0);

    // Reset in the middle of the first squaring (well past reduce+multiply).
    start(16'd3, 16'd5, 16'd7);
    repeat (88) @(negedge clk);
    check("pre_rst_busy", 32'(bus.busy_out), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 32'(bus.busy_out), 32'd0);
    check("midrst_valid", 32'(bus.valid_out), 32'd0);
    check("midrst_result", 32'(bus.result_out), 32'd0);
    saw = 1'b0;
    repeat (150) begin
      @(negedge clk);
      if (bus.valid_out || bus.busy_out) saw = 1'b1;
    end
    check("midrst_quiet", 32'(saw), 32'd0);
    run("post_rst_3^5m7", 16'd3, 16'd5, 16'd7, 16'd5, 1'b0);

    // (m-1)^odd = m-1 mod m; worst-case exponent length.
    run("m1_allones_65521", 16'd65520, 16'hFFFF, 16'd65521, 16'd65520, 1'b0);
    run("big_base", 16'hFFFF, 16'd2, 16'd65521, 16'd196, 1'b0);

    for (int i = 0; i < 5; i++) begin
      rb = 16'($urandom);
      re = 16'($urandom);
      rm = 16'($urandom_range(2, 65535));
      run($sformatf("rand%0d", i), rb, re, rm, ref_exp(rb, re, rm), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
